// File: rtl/vga_fb_pixel.sv
// rtl/vga_fb_pixel.sv - framebuffer pixel-colour stage behind the VGA timing generator
// Optional white border overlay: define VGA_FB_PIXEL_BORDER_EN.
module vga_fb_pixel #(
   parameter int PIXEL_BITS = 4,
   parameter int H_BITS = 10,
   parameter int V_BITS = 10,
   parameter int FB_W = 160,
   parameter int FB_H = 120,
   parameter int SCALE_SHIFT = 2,
   parameter logic [3*PIXEL_BITS-1:0] CLEAR_COLOR = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [H_BITS-1:0]         vga_x,
   input  logic [V_BITS-1:0]         vga_y,
   input  logic                      vga_active,
   input  logic                      h_sync_in,
   input  logic                      v_sync_in,
   output logic [PIXEL_BITS-1:0]     vga_r,
   output logic [PIXEL_BITS-1:0]     vga_g,
   output logic [PIXEL_BITS-1:0]     vga_b,
   output logic                      h_sync,
   output logic                      v_sync,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [$clog2(FB_W)-1:0]   wr_x,
   input  logic [$clog2(FB_H)-1:0]   wr_y,
   input  logic [3*PIXEL_BITS-1:0]   wr_data,
   input  logic                      clear_req,
   output logic                      clear_busy
);

   localparam int WORD_W = 3 * PIXEL_BITS;
   localparam int DEPTH  = FB_W * FB_H;
   localparam int AW     = $clog2(DEPTH);

   typedef enum logic {IDLE, CLEAR} clr_state_t;

   logic [WORD_W-1:0] ram [DEPTH];

   clr_state_t state, state_n;
   logic [AW-1:0] clr_cnt, clr_cnt_n;

   // S0 combinational: scaled coordinates, range test on full-width values
   logic [H_BITS-1:0] fx;
   logic [V_BITS-1:0] fy;
   logic              in_range;
   logic [AW-1:0]     rd_addr;

   always_comb begin
      fx       = vga_x >> SCALE_SHIFT;
      fy       = vga_y >> SCALE_SHIFT;
      in_range = (32'(fx) < 32'(FB_W)) && (32'(fy) < 32'(FB_H));
      rd_addr  = in_range ? (AW'(fy) * AW'(FB_W) + AW'(fx)) : '0;
   end

   logic          s0_rd_en;
   logic [AW-1:0] s0_addr;
   logic          s0_hs, s0_vs;
`ifdef VGA_FB_PIXEL_BORDER_EN
   localparam logic [H_BITS-1:0] X_LAST = H_BITS'((FB_W << SCALE_SHIFT) - 1);
   localparam logic [V_BITS-1:0] Y_LAST = V_BITS'((FB_H << SCALE_SHIFT) - 1);
   logic s0_border;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_rd_en <= 1'b0;
         s0_addr  <= '0;
         s0_hs    <= 1'b1;
         s0_vs    <= 1'b1;
`ifdef VGA_FB_PIXEL_BORDER_EN
         s0_border <= 1'b0;
`endif
      end else begin
         s0_rd_en <= vga_active && in_range;
         s0_addr  <= rd_addr;
         s0_hs    <= h_sync_in;
         s0_vs    <= v_sync_in;
`ifdef VGA_FB_PIXEL_BORDER_EN
         s0_border <= vga_active && ((vga_x == '0) || (vga_y == '0) ||
                                     (vga_x == X_LAST) || (vga_y == Y_LAST));
`endif
      end
   end

   // S1: synchronous RAM read lands directly in the output register
   logic [WORD_W-1:0] rgb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q  <= '0;
         h_sync <= 1'b1;
         v_sync <= 1'b1;
      end else begin
         h_sync <= s0_hs;
         v_sync <= s0_vs;
`ifdef VGA_FB_PIXEL_BORDER_EN
         if (s0_border)
            rgb_q <= '1;
         else if (s0_rd_en)
            rgb_q <= ram[s0_addr];
         else
            rgb_q <= '0;
`else
         if (s0_rd_en)
            rgb_q <= ram[s0_addr];
         else
            rgb_q <= '0;
`endif
      end
   end

   assign vga_r = rgb_q[3*PIXEL_BITS-1:2*PIXEL_BITS];
   assign vga_g = rgb_q[2*PIXEL_BITS-1:PIXEL_BITS];
   assign vga_b = rgb_q[PIXEL_BITS-1:0];

   // Clear FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         clr_cnt <= '0;
      end else begin
         state   <= state_n;
         clr_cnt <= clr_cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      clr_cnt_n = clr_cnt;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_n   = CLEAR;
               clr_cnt_n = '0;
            end
         end
         CLEAR: begin
            if (clr_cnt == AW'(DEPTH - 1)) begin
               state_n   = IDLE;
               clr_cnt_n = '0;
            end else begin
               clr_cnt_n = clr_cnt + AW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign clear_busy = (state == CLEAR);
   assign wr_ready   = !clear_busy;

   // Single RAM write port shared by the clear engine and the user port
   logic              wr_hit;
   logic              ram_we;
   logic [AW-1:0]     ram_wa;
   logic [WORD_W-1:0] ram_wd;

   always_comb begin
      wr_hit = wr_valid && wr_ready &&
               (32'(wr_x) < 32'(FB_W)) && (32'(wr_y) < 32'(FB_H));
      if (clear_busy) begin
         ram_we = 1'b1;
         ram_wa = clr_cnt;
         ram_wd = CLEAR_COLOR;
      end else begin
         ram_we = wr_hit;
         ram_wa = AW'(wr_y) * AW'(FB_W) + AW'(wr_x);
         ram_wd = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_wa] <= ram_wd;
   end

endmodule

// File: doc/vga_fb_pixel.md
Name: vga_fb_pixel

Overview:
- Pixel-colour stage directly downstream of the vga timing generator.
- Consumes vga_x, vga_y, vga_active, h_sync and v_sync from the generator, looks up colour in an internal dual-port framebuffer, and drives RGB plus pipeline-aligned syncs to the pins.
- Framebuffer is FB_W x FB_H words, upscaled by 2^SCALE_SHIFT in each axis. A valid/ready write port lets upstream logic (inference/debug) paint pixels; a hardware clear engine fills the buffer with CLEAR_COLOR.

Parameters:
- PIXEL_BITS, 4, bits per colour channel; a word is 3*PIXEL_BITS bits, packed {r,g,b}.
- H_BITS, 10, width of vga_x.
- V_BITS, 10, width of vga_y.
- FB_W, 160, framebuffer width in words.
- FB_H, 120, framebuffer height in words.
- SCALE_SHIFT, 2, screen pixels per framebuffer pixel = 2^SCALE_SHIFT per axis.
- CLEAR_COLOR, 0, word written by the clear engine.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- vga_x  in  H_BITS  current column from the timing generator
- vga_y  in  V_BITS  current row from the timing generator
- vga_active  in  1  visible-region flag
- h_sync_in  in  1  raw hsync from the timing generator
- v_sync_in  in  1  raw vsync from the timing generator
- vga_r  out  PIXEL_BITS  red
- vga_g  out  PIXEL_BITS  green
- vga_b  out  PIXEL_BITS  blue
- h_sync  out  1  delayed hsync
- v_sync  out  1  delayed vsync
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high with wr_valid
- wr_x  in  clog2(FB_W)  write column
- wr_y  in  clog2(FB_H)  write row
- wr_data  in  3*PIXEL_BITS  {r,g,b} word
- clear_req  in  1  single-cycle pulse; starts a clear
- clear_busy  out  1  clear in progress

Behaviour:
- Reset (asynchronous): vga_r/g/b = 0, h_sync = v_sync = 1, clear FSM = IDLE, clear_busy = 0, all pipeline valid bits = 0.
- Framebuffer RAM contents are not reset.
- Read pipeline, 2 clk latency, inputs sampled every clk:
  - S0 registers fx = vga_x>>SCALE_SHIFT and fy = vga_y>>SCALE_SHIFT, in_range = (fx<FB_W)&&(fy<FB_H), address = fy*FB_W+fx, and active/sync.
  - S1 performs the synchronous RAM read.
  - Output registers: rgb = (active && in_range) ? word : 0.
  - h_sync/v_sync are the inputs delayed exactly 2 clk, so colour and sync stay aligned.
- Address arithmetic is full width with no truncation. Out-of-range addresses never access the RAM.
- Write port:
  - wr_ready = !clear_busy (combinational from FSM state).
  - A transfer occurs when wr_valid && wr_ready.
  - Coordinates with wr_x>=FB_W or wr_y>=FB_H are accepted but discarded.
  - The write lands in the RAM at the end of the accepting cycle.
- RAM is read-before-write: a read and a write to the same address in the same cycle returns the old word.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clear_req=1: next cycle CLEAR, clear_busy=1, counter=0.
  - CLEAR: writes CLEAR_COLOR at address counter, counter+1 each cycle. After writing address FB_W*FB_H-1, returns to IDLE and clear_busy falls. clear_busy is high for exactly FB_W*FB_H cycles.
  - clear_req during CLEAR is ignored (no restart).
  - clear_req and a valid write in the same IDLE cycle: the write is accepted, then the clear overwrites it.
- Display reads continue during a clear and show partially cleared content.
- rst mid-clear: FSM returns to IDLE, clear_busy=0, RAM left partially cleared.

Optional Feature:
- Macro: VGA_FB_PIXEL_BORDER_EN.
- With the macro defined: any active pixel with vga_x==0, vga_y==0, vga_x==(FB_W<<SCALE_SHIFT)-1 or vga_y==(FB_H<<SCALE_SHIFT)-1 outputs all channels at maximum (white). The override is applied at the output register and keeps the 2 clk latency.
- Without the macro: no override logic is present; output is framebuffer colour only.

Test Plan:
- Reset: assert rst asynchronously mid-frame -> rgb=0 and h_sync=v_sync=1 immediately; clear_busy=0; wr_ready=1.
- Clear then write: pulse clear_req -> clear_busy high for 19200 cycles. Then write (3,2)=12'hF0A. Drive x=12..15, y=8..11 with active=1 -> rgb = F,0,A two clk later. Neighbours (x=16, y=8) read 0.
- Sync alignment: feed a timing-generator pattern (800x525) -> h_sync/v_sync equal the inputs delayed 2 clk. rgb=0 whenever the delayed active=0.
- Out of range: write wr_x=200 -> handshake completes, RAM unchanged. Reads with x>=640 or y>=480 (active forced 1) -> rgb=0.
- Clear interactions: during CLEAR, wr_valid=1 sees wr_ready=0 with no write; a second clear_req has no effect on duration. rst at cycle 100 of a clear -> clear_busy=0 next edge, and subsequent writes accepted.
- With VGA_FB_PIXEL_BORDER_EN defined: x=0, y=100, active -> rgb=F,F,F. Without the macro -> rgb equals framebuffer word.
